// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with a valid/ready handshake.
// Operands are split into BLK-bit skip blocks; each pipeline stage resolves
// BPS blocks, and a single carry bit is registered between stages.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               clears every in-flight beat on the next edge
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   in_a, in_b          operands
//   in_cin              carry-in for add; ignored when subtracting
//   in_sub              1: A-B, 0: A+B+cin
//   out_valid/out_ready result handshake
//   out_sum, out_cout   result and carry-out (cout=1 means no borrow on sub)
//   out_ovf             two's-complement signed overflow
//   out_skip_cnt        number of blocks whose block-propagate was 1
module cskip_adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 4,
    parameter int unsigned BPS   = 2,
    parameter int unsigned SCW   = $clog2(WIDTH / BLK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [SCW-1:0]   out_skip_cnt
);

    localparam int unsigned STG_W  = BLK * BPS;
    localparam int unsigned STAGES = WIDTH / STG_W;

    // Reject geometries that cannot be tiled into whole stages.
    if ((BLK < 1) || (BPS < 1) || ((WIDTH % STG_W) != 0)) begin : g_bad_geometry
        $error("cskip_adder_pipe: WIDTH must be a multiple of BLK*BPS and BLK >= 1");
    end

    // One beat in flight. a/b hold the operand bits not yet consumed (LSB
    // aligned); sum fills from the top as each stage shifts its slice in.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             ovf;
        logic [SCW-1:0]   skip;
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    logic   adv;
    stage_t in_d;
    stage_t in_q;
    stage_t last;

    // Whole pipeline moves only when the output slot is free or being taken.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv && !flush;

    // Capture effective operands: subtraction is A + ~B + 1.
    always_comb begin : capture
        in_d       = '0;
        in_d.valid = in_valid;
        in_d.carry = in_sub ? 1'b1 : in_cin;
        in_d.a     = in_a;
        in_d.b     = in_sub ? ~in_b : in_b;
        in_d.a_msb = in_a[WIDTH-1];
        in_d.b_msb = in_d.b[WIDTH-1];
    end

    // Operand capture register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q <= '0;
        end else if (flush) begin
            in_q.valid <= 1'b0;
        end else if (adv) begin
            in_q <= in_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t src;
        stage_t nxt;
        stage_t q_q;

        if (k == 0) begin : g_first
            assign src = in_q;
        end else begin : g_rest
            assign src = g_stage[k-1].q_q;
        end

        // Resolve BPS skip blocks: ripple inside each block, bypass the
        // block's carry-in whenever every bit of the block propagates.
        always_comb begin : resolve
            logic [STG_W-1:0] sa;
            logic [STG_W-1:0] sb;
            logic [STG_W-1:0] ss;
            logic [WIDTH-1:0] sum_n;
            logic [SCW-1:0]   cnt;
            logic             c;
            logic             rc;
            logic             bc;
            logic             p;
            logic             x;

            sa    = src.a[STG_W-1:0];
            sb    = src.b[STG_W-1:0];
            ss    = '0;
            cnt   = src.skip;
            c     = src.carry;
            rc    = 1'b0;
            bc    = 1'b0;
            p     = 1'b0;
            x     = 1'b0;
            for (int unsigned j = 0; j < BPS; j++) begin
                bc = c;
                rc = c;
                p  = 1'b1;
                for (int unsigned i = 0; i < BLK; i++) begin
                    x                = sa[j*BLK+i] ^ sb[j*BLK+i];
                    ss[j*BLK+i]      = x ^ rc;
                    rc               = (sa[j*BLK+i] & sb[j*BLK+i]) | (rc & x);
                    p                = p & x;
                end
                c   = p ? bc : rc;
                cnt = cnt + SCW'(p);
            end
            sum_n = (src.sum >> STG_W) | (WIDTH'(ss) << (WIDTH - STG_W));

            nxt       = src;
            nxt.carry = c;
            nxt.skip  = cnt;
            nxt.sum   = sum_n;
            nxt.a     = src.a >> STG_W;
            nxt.b     = src.b >> STG_W;
            nxt.ovf   = (src.a_msb == src.b_msb) && (sum_n[WIDTH-1] != src.a_msb);
        end

        // Stage register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_q <= '0;
            end else if (flush) begin
                q_q.valid <= 1'b0;
            end else if (adv) begin
                q_q <= nxt;
            end
        end
    end

    assign last         = g_stage[STAGES-1].q_q;
    assign out_valid    = last.valid;
    assign out_sum      = last.sum;
    assign out_cout     = last.carry;
    assign out_ovf      = last.ovf;
    assign out_skip_cnt = last.skip;

    // Operand bits are fully consumed by the final stage.
    logic unused_tail;
    assign unused_tail = ^{last.a, last.b, last.a_msb, last.b_msb};

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Scoreboard bench for cskip_adder_pipe (default parameters).
module tb_cskip_adder_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BLK   = 4;
    localparam int unsigned BPS   = 2;
    localparam int unsigned NBLK  = WIDTH / BLK;
    localparam int unsigned SCW   = $clog2(NBLK + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [SCW-1:0]   out_skip_cnt;

    always #5 clk = ~clk;

    cskip_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK), .BPS(BPS), .SCW(SCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_cin       (in_cin),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_cout     (out_cout),
        .out_ovf      (out_ovf),
        .out_skip_cnt (out_skip_cnt)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic [SCW-1:0]   skip;
    } res_t;

    res_t exp_q[$];
    res_t mon_got;
    res_t mon_exp;
    int   checks   = 0;
    int   failures = 0;
    logic rand_done;

    // Reference: plain wide addition plus a count of all-ones XOR blocks.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t           r;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] px;
        int             cnt;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + (WIDTH + 1)'(sub ? 1'b1 : cin);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        px  = a ^ bp;
        cnt = 0;
        for (int j = 0; j < int'(NBLK); j++) begin
            if (((px >> (j * BLK)) & WIDTH'((1 << BLK) - 1)) == WIDTH'((1 << BLK) - 1))
                cnt++;
        end
        r.skip = SCW'(cnt);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: record the expected response of every accepted beat.
    always @(negedge clk) begin
        if (!rst_n || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    end

    // Monitor: compare every retired result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            mon_got = '{sum: out_sum, cout: out_cout, ovf: out_ovf, skip: out_skip_cnt};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none (t=%0t)", mon_got, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    // Offer one beat and hold it until accepted.
    task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
        logic ok;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Directed vector on an idle pipe: checks latency and exact result.
    task automatic run_vec(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input res_t want);
        int cyc;
        check({name, "_acc"}, 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            cyc = t;
            if (out_valid) break;
        end
        check({name, "_lat"}, 64'(cyc), 64'd4);
        check(name, 64'({out_sum, out_cout, out_ovf, out_skip_cnt}), 64'(want));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [38:0]      snap;
        logic             seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        repeat (2) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'({out_sum, out_cout, out_ovf, out_skip_cnt}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);

        // Directed vectors
        run_vec("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0, 4'd7});
        run_vec("sub_neg",  32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 4'd7});
        run_vec("sub_pos",  32'd7, 32'd5, 1'b0, 1'b1, '{32'h2, 1'b1, 1'b0, 4'd7});
        run_vec("ovf_pos",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 4'd6});
        run_vec("ovf_neg",  32'h8000_0000, 32'h1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 4'd6});
        run_vec("cin_all",  32'h0000_000F, 32'hFFFF_FFF0, 1'b1, 1'b0, '{32'h0, 1'b1, 1'b0, 4'd8});
        run_vec("zero",     32'h0, 32'h0, 1'b0, 1'b0, '{32'h0, 1'b0, 1'b0, 4'd0});
        repeat (2) tick();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(3) == 0) tick();
                    ra = $urandom;
                    case ($urandom_range(3))
                        0:       rb = ~ra ^ (WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom));
                        1:       rb = ra;
                        default: rb = $urandom;
                    endcase
                    send_beat(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure: stall the first result for three cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_beat(WIDTH'(i) * 32'h1111_1111 + 32'd3, 32'h0F0F_0000 + WIDTH'(i), 1'b0, 1'(i % 2));
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("bp_seen", 64'(seen), 64'd1);
                snap = {out_valid, out_sum, out_cout, out_ovf, out_skip_cnt};
                check("bp_ready0", 64'(in_ready), 64'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("bp_hold", 64'({out_valid, out_sum, out_cout, out_ovf, out_skip_cnt}), 64'(snap));
                    check("bp_ready0", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("bp_nogap", 64'(out_valid), 64'd1);
                end
            end
        join
        repeat (4) tick();
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // Reset with three beats in flight
        send_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        send_beat(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        send_beat(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'({out_sum, out_cout, out_ovf, out_skip_cnt}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_rst_gone", 64'(out_valid), 64'd0);
        end
        tick();

        // Flush colliding with an offered beat
        send_beat(32'h0000_0AAA, 32'h0000_0555, 1'b0, 1'b0);
        send_beat(32'h0BAD_F00D, 32'h0000_1000, 1'b0, 1'b1);
        in_a     = 32'h5555_5555;
        in_b     = 32'h2222_2222;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_empty", 64'(out_valid), 64'd0);
        end
        repeat (6) tick();
        run_vec("post_flush", 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, '{32'h8, 1'b0, 1'b0, 4'd0});
        repeat (3) tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cskip_adder_pipe.md
# cskip_adder_pipe

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready handshake. Operands are split into BLK-bit skip blocks, and BPS blocks are resolved per pipeline stage, with one carry register between stages. The block replaces fixed-width combinational carry-skip adders in datapaths that need a registered, back-pressurable arithmetic unit at a higher clock rate. Each result also reports signed overflow and how many blocks had their carry bypassed.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLK*BPS
- BLK, 4, bits per skip block
- BPS, 2, skip blocks per pipeline stage; STAGES = WIDTH/(BLK*BPS)
- SCW, $clog2(WIDTH/BLK+1), width of skip_cnt
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  synchronous clear of all in-flight operations
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in, used only when in_sub=0
- in_sub  in  1  1: A-B, 0: A+B+cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out; in subtract mode 1 means no borrow
- out_ovf  out  1  two's-complement signed overflow
- out_skip_cnt  out  SCW  number of blocks whose block-propagate was 1

## Operation
- Effective operands: B' = in_sub ? ~in_b : in_b. Effective carry-in c0 = in_sub ? 1 : in_cin.
- Block j covers bits [j*BLK +: BLK]:
  - P_j = &(A^B') over the block.
  - Block carry-out = P_j ? block carry-in : ripple carry-out.
  - Each P_j=1 adds 1 to skip_cnt.
- Stage k resolves bits [k*BLK*BPS +: BLK*BPS] using the carry registered by stage k-1. Stage 0 uses c0.
- Not-yet-consumed operand bits and the already-produced sum bits travel with each beat in stage registers. Per-stage state is: valid, carry, partial sum, remaining A/B', sign bits needed for ovf, and partial skip_cnt.
- out_cout is the carry out of bit WIDTH-1.
- out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- The sum is modulo 2^WIDTH. skip_cnt ranges from 0 to WIDTH/BLK.
- Pipeline advance: adv = out_ready || !out_valid. The whole pipeline shifts only when adv=1. When adv=0 every stage holds.
- in_ready = adv && !flush. A beat is accepted when in_valid && in_ready.
- Flush: on the next edge every stage valid, including out_valid, goes to 0. A beat offered in the same cycle is not accepted. Flush overrides out_ready.
- Reset (rst_n=0 at an edge): all valids are 0. out_sum, out_cout, out_ovf and out_skip_cnt are 0. In-flight beats are discarded. in_ready is combinational and reads 1 once rst_n=1 and flush=0.
- A bubble (no accept) propagates as valid=0. Its data registers may hold stale values but must not reach out_valid=1.
- Results emerge in acceptance order. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES, assuming adv=1 throughout. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Outputs are registered and stay stable while out_valid=1 && out_ready=0.
- Accept and retire can happen in the same cycle at full rate.
- Critical path per stage: BLK-bit ripple plus BPS skip muxes.
- Elaboration error if WIDTH % (BLK*BPS) != 0 or BLK < 1.

## Test plan
All cases use defaults: STAGES=4, latency 4.
- Add wrap: in_a=0xFFFFFFFF, in_b=0x00000001, cin=0 → 4 cycles later sum=0x00000000, cout=1, ovf=0, skip_cnt=7.
- Subtract: in_a=5, in_b=7, in_sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0, skip_cnt=7. With in_a=7, in_b=5 → sum=0x00000002, cout=1.
- Signed overflow: in_a=0x7FFFFFFF, in_b=1, add → sum=0x80000000, cout=0, ovf=1, skip_cnt=6.
- Backpressure: issue 6 consecutive beats with distinct operands and hold out_ready=0 for 3 cycles once the first result appears → outputs stay constant and in_ready=0 while stalled. All 6 results then appear in order with no gaps after out_ready=1.
- Reset mid-flight: 3 beats in flight, rst_n=0 for one edge → out_valid=0, all output data 0, the 3 beats never appear. in_ready=1 on the first cycle after release.
- Flush collision: 2 beats in flight, flush=1 and in_valid=1 in the same cycle → in_ready=0 that cycle, out_valid=0 for the next 4 cycles, and no result ever appears for the offered beat.
